// File: rtl/carry_lookahead_bist.sv
// Self-test driver/checker for the 32-bit carry-lookahead network: applies corner and LFSR
// operand pairs, waits for settle, and compares the network's carry vector with a ripple reference.
module carry_lookahead_bist #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned NUM_VECTORS   = 256,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED_A        = 32'h1ACE5EED,
  parameter logic [31:0] SEED_B        = 32'hC0FFEE01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dut_c,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_c
);

  localparam logic [16:0] LAST_VEC    = 17'(NUM_VECTORS + 3);
  localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [31:0] LFSR_POLY   = 32'h80200003;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [16:0]      vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      lfsr_a_q, lfsr_a_d;
  logic [31:0]      lfsr_b_q, lfsr_b_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d;
  logic [WIDTH-1:0] dut_b_q, dut_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [15:0]      err_q, err_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic [WIDTH-1:0] fail_c_q, fail_c_d;

  logic             start_s;
  logic             apply_s;
  logic             wait_s;
  logic             check_s;
  logic             last_vec_s;
  logic             mismatch_s;
  logic [15:0]      err_inc_s;
  logic [31:0]      ref_c_s;

  // Galois right-shift step; a nonzero seed never reaches the all-zero state.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) begin
      y = y ^ LFSR_POLY;
    end else begin
      y = y;
    end
    return y;
  endfunction

  // Bit i of the result is the carry out of bit i with carry-in 0.
  function automatic logic [31:0] ref_carry(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [32:0] k;
    s = {1'b0, a} + {1'b0, b};
    k = s ^ {1'b0, a} ^ {1'b0, b};
    return k[32:1];
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_APPLY : S_IDLE;
      S_APPLY: state_d = S_WAIT;
      S_WAIT:  state_d = (cnt_q <= 4'd1) ? S_CHECK : S_WAIT;
      S_CHECK: state_d = last_vec_s ? S_DONE : S_APPLY;
      S_DONE:  state_d = start ? S_APPLY : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State decode for the datapath.
  always_comb begin
    start_s = 1'b0;
    apply_s = 1'b0;
    wait_s  = 1'b0;
    check_s = 1'b0;
    case (state_q)
      S_IDLE:  start_s = start;
      S_APPLY: apply_s = 1'b1;
      S_WAIT:  wait_s  = 1'b1;
      S_CHECK: check_s = 1'b1;
      S_DONE:  start_s = start;
      default: start_s = 1'b0;
    endcase
  end

  assign last_vec_s = (vec_q == LAST_VEC);
  assign ref_c_s    = ref_carry(dut_a_q, dut_b_q);
  assign mismatch_s = (dut_c != ref_c_s);
  assign err_inc_s  = (err_q == 16'hFFFF) ? err_q : (err_q + 16'd1);

  // Datapath next-state: run setup, vector apply, settle count and result update.
  always_comb begin
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    dut_a_d  = dut_a_q;
    dut_b_d  = dut_b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    fail_c_d = fail_c_q;
    if (start_s) begin
      vec_d    = 17'd0;
      cnt_d    = 4'd0;
      lfsr_a_d = SEED_A;
      lfsr_b_d = SEED_B;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      err_d    = 16'd0;
      fail_a_d = 32'd0;
      fail_b_d = 32'd0;
      fail_c_d = 32'd0;
    end else if (apply_s) begin
      cnt_d = SETTLE_INIT;
      case (vec_q)
        17'd0: begin
          dut_a_d = 32'hFFFFFFFF;
          dut_b_d = 32'h00000000;
        end
        17'd1: begin
          dut_a_d = 32'hA47BA47B;
          dut_b_d = 32'h5C915C91;
        end
        17'd2: begin
          dut_a_d = 32'hBCDABCDA;
          dut_b_d = 32'h79867986;
        end
        17'd3: begin
          dut_a_d = 32'h96579657;
          dut_b_d = 32'h34563456;
        end
        default: begin
          dut_a_d  = lfsr_a_q;
          dut_b_d  = lfsr_b_q;
          lfsr_a_d = lfsr_step(lfsr_a_q);
          lfsr_b_d = lfsr_step(lfsr_b_q);
        end
      endcase
    end else if (wait_s) begin
      cnt_d = cnt_q - 4'd1;
    end else if (check_s) begin
      // Only the first mismatch of a run is captured; later ones just count.
      if (mismatch_s) begin
        err_d = err_inc_s;
        if (err_q == 16'd0) begin
          fail_a_d = dut_a_q;
          fail_b_d = dut_b_q;
          fail_c_d = dut_c;
        end else begin
          fail_a_d = fail_a_q;
        end
      end else begin
        err_d = err_q;
      end
      if (last_vec_s) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = (err_d == 16'd0);
      end else begin
        vec_d = vec_q + 17'd1;
      end
    end else begin
      vec_d = vec_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= 17'd0;
      cnt_q    <= 4'd0;
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      dut_a_q  <= 32'd0;
      dut_b_q  <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 16'd0;
      fail_a_q <= 32'd0;
      fail_b_q <= 32'd0;
      fail_c_q <= 32'd0;
    end else begin
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      dut_a_q  <= dut_a_d;
      dut_b_q  <= dut_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      fail_c_q <= fail_c_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_c    = fail_c_q;

endmodule

// File: tb/tb_carry_lookahead_bist.sv
// Bench for carry_lookahead_bist: a behavioural ripple network (with optional injected faults)
// drives dut_c; expected operands and results come from a bench-side vector model.
module tb_carry_lookahead_bist;

  localparam int NV  = 8;
  localparam int S   = 2;
  localparam int V   = 4 + NV;
  localparam logic [31:0] SEED_A = 32'h1ACE5EED;
  localparam logic [31:0] SEED_B = 32'hC0FFEE01;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dut_c;
  logic [31:0] dut_a;
  logic [31:0] dut_b;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [31:0] fail_a;
  logic [31:0] fail_b;
  logic [31:0] fail_c;

  logic        tie0;
  logic [31:0] stuck_mask;

  int checks;
  int errors;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  logic [15:0] exp_err;
  logic [31:0] exp_fa;
  logic [31:0] exp_fb;
  logic [31:0] exp_fc;
  logic [31:0] last_a;

  logic [31:0] corner_a [4] = '{32'hFFFFFFFF, 32'hA47BA47B, 32'hBCDABCDA, 32'h96579657};
  logic [31:0] corner_b [4] = '{32'h00000000, 32'h5C915C91, 32'h79867986, 32'h34563456};

  carry_lookahead_bist #(
    .WIDTH(32), .NUM_VECTORS(NV), .SETTLE_CYCLES(S), .SEED_A(SEED_A), .SEED_B(SEED_B)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_c(dut_c),
    .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b), .fail_c(fail_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ripple(input logic [31:0] a, input logic [31:0] b);
    logic        c;
    logic [31:0] r;
    c = 1'b0;
    for (int i = 0; i < 32; i++) begin
      c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      r[i] = c;
    end
    return r;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h80200003;
    return y;
  endfunction

  function automatic logic [31:0] net_out(input logic [31:0] a, input logic [31:0] b,
                                          input logic t0, input logic [31:0] m);
    return t0 ? 32'h0 : (ripple(a, b) & ~m);
  endfunction

  // Network under test: ideal ripple carries with optional faults.
  always_comb dut_c = net_out(dut_a, dut_b, tie0, stuck_mask);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expected operand sequence and derive the expected run result for the current fault.
  task automatic build_expected();
    logic [31:0] la, lb, a, b, c;
    exp_a_q.delete();
    exp_b_q.delete();
    la = SEED_A;
    lb = SEED_B;
    exp_err = 16'd0;
    exp_fa = 32'd0;
    exp_fb = 32'd0;
    exp_fc = 32'd0;
    for (int v = 0; v < V; v++) begin
      if (v < 4) begin
        a = corner_a[v];
        b = corner_b[v];
      end else begin
        a = la;
        b = lb;
        la = lfsr_next(la);
        lb = lfsr_next(lb);
      end
      exp_a_q.push_back(a);
      exp_b_q.push_back(b);
      c = net_out(a, b, tie0, stuck_mask);
      if (c != ripple(a, b)) begin
        if (exp_err == 16'd0) begin
          exp_fa = a;
          exp_fb = b;
          exp_fc = c;
        end
        exp_err = exp_err + 16'd1;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One full run with fixed-cycle sampling; optional start pulse during vector mid_k.
  task automatic run_full(input int mid_k);
    logic [31:0] ea, eb;
    build_expected();
    pulse_start();
    chk("busy_on_start", {31'd0, busy}, 32'd1);
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("pass_cleared", {31'd0, pass}, 32'd0);
    chk("err_cleared", {16'd0, err_count}, 32'd0);
    chk("fail_a_cleared", fail_a, 32'd0);
    for (int k = 0; k < V; k++) begin
      repeat (S + 1) @(posedge clk);
      @(negedge clk);
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      chk($sformatf("dut_a_v%0d", k), dut_a, ea);
      chk($sformatf("dut_b_v%0d", k), dut_b, eb);
      last_a = ea;
      if (k == V - 1) begin
        chk("done_before_end", {31'd0, done}, 32'd0);
        chk("busy_before_end", {31'd0, busy}, 32'd1);
      end
      if (k == mid_k) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("done_at_end", {31'd0, done}, 32'd1);
    chk("busy_at_end", {31'd0, busy}, 32'd0);
    chk("pass_at_end", {31'd0, pass}, {31'd0, (exp_err == 16'd0)});
    chk("err_count", {16'd0, err_count}, {16'd0, exp_err});
    chk("fail_a", fail_a, exp_fa);
    chk("fail_b", fail_b, exp_fb);
    chk("fail_c", fail_c, exp_fc);
    repeat (3) @(negedge clk);
    chk("done_held", {31'd0, done}, 32'd1);
    chk("dut_a_held", dut_a, last_a);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_dut_a"}, dut_a, 32'd0);
    chk({pfx, "_dut_b"}, dut_b, 32'd0);
    chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    chk({pfx, "_done"}, {31'd0, done}, 32'd0);
    chk({pfx, "_pass"}, {31'd0, pass}, 32'd0);
    chk({pfx, "_err"}, {16'd0, err_count}, 32'd0);
    chk({pfx, "_fail_a"}, fail_a, 32'd0);
    chk({pfx, "_fail_b"}, fail_b, 32'd0);
    chk({pfx, "_fail_c"}, fail_c, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    tie0 = 1'b0;
    stuck_mask = 32'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Golden network.
    run_full(-1);

    // Carry bit 13 stuck at 0: first failure is corner vector 1.
    stuck_mask = 32'h00002000;
    run_full(-1);
    chk("stuck_fail_a_const", fail_a, 32'hA47BA47B);
    chk("stuck_fail_c_const", fail_c, 32'hFCF3DCF3);

    // Golden rerun from DONE with a start pulse while busy.
    stuck_mask = 32'd0;
    run_full(5);

    // Reset during WAIT of v2 with an error already recorded.
    stuck_mask = 32'h00002000;
    build_expected();
    pulse_start();
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("abort_dut_a_v2", dut_a, 32'hBCDABCDA);
    chk("abort_err_before", {16'd0, err_count}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    exp_a_q.delete();
    exp_b_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stuck_mask = 32'd0;
    repeat (2) @(negedge clk);
    chk("after_abort_idle", {31'd0, busy}, 32'd0);
    run_full(-1);

    // Network output tied low.
    tie0 = 1'b1;
    run_full(-1);
    chk("tie0_fail_a_const", fail_a, 32'hA47BA47B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
